// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: three-stage pipelined floating-point add/subtract.
//   Operands are {sign, exp, frac}. Subnormal inputs are flushed to zero.
//   Rounding is round-to-nearest, ties-to-even.
//   A subnormal result is flushed to signed zero and raises underflow.
//   S1 unpacks the operands, orders them by magnitude and aligns the smaller one.
//   S2 adds or subtracts the magnitudes.
//   S3 normalises, rounds, applies special cases and packs the result.
//   All three stages advance together, so bubbles are not collapsed.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_valid, o_ready  operand handshake (i_op: 0 add, 1 subtract)
//   data_1, data_2    operands A and B
//   o_valid, i_ready  result handshake
//   o_data, o_flags   result and {invalid, overflow, underflow, inexact}
module fp_addsub_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10,
   localparam int W = 1 + EXP_W + MAN_W
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic         i_op,
   input  logic [W-1:0] data_1,
   input  logic [W-1:0] data_2,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic [3:0]   o_flags
);
   // Extended mantissa is {hidden, frac, guard, round, sticky}.
   localparam int MX     = MAN_W + 4;
   localparam int SH_MAX = MAN_W + 3;
   localparam int LZ_W   = $clog2(MX + 1);
   localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef struct packed {
      logic nan;   // result is the canonical NaN
      logic inf;   // result is an infinity
      logic inv;   // inf - inf
      logic sgn;   // sign of the infinity
      logic zsgn;  // sign of an exact zero result
   } spc_t;

   // Priority encoder: number of leading zeros (MX when v is all zero).
   function automatic logic [LZ_W-1:0] lzc(input logic [MX-1:0] v);
      logic [LZ_W-1:0] n;
      n = LZ_W'(MX);
      for (int i = 0; i < MX; i++)
         if (v[i]) n = LZ_W'(MX - 1 - i);
      return n;
   endfunction

   logic en;
   logic [3:1] vld_q, vld_d;
   assign en      = ~vld_q[3] | i_ready;
   assign o_ready = en;
   assign o_valid = vld_q[3];
   assign vld_d   = {vld_q[2:1], i_valid};

   // ---------------- S1: unpack / order / align ----------------
   logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0] ea, eb, diff, sh;
   logic [MAN_W-1:0] fa, fb;
   logic [MAN_W:0]   mant_a, mant_b;
   logic [MAN_W+2:0] mb_in, mb_al, lost_mask;
   logic             s1_sign_d, s1_sub_d, s1_sign_q, s1_sub_q;
   logic [EXP_W-1:0] s1_exp_d, s1_exp_q;
   logic [MX-1:0]    s1_ma_d, s1_mb_d, s1_ma_q, s1_mb_q;
   spc_t             s1_spc_d, s1_spc_q;

   always_comb begin
      sa = data_1[W-1];
      ea = data_1[W-2:MAN_W];
      fa = data_1[MAN_W-1:0];
      sb = data_2[W-1] ^ i_op;
      eb = data_2[W-2:MAN_W];
      fb = data_2[MAN_W-1:0];
      a_zero = (ea == '0);
      b_zero = (eb == '0);
      a_nan  = (&ea) & (|fa);
      b_nan  = (&eb) & (|fb);
      a_inf  = (&ea) & ~(|fa);
      b_inf  = (&eb) & ~(|fb);
      mant_a = a_zero ? '0 : {1'b1, fa};
      mant_b = b_zero ? '0 : {1'b1, fb};
      // A flushed subnormal has exp=0 and a zero mantissa, so it compares as zero.
      swap   = {eb, mant_b[MAN_W-1:0]} > {ea, mant_a[MAN_W-1:0]};
      diff   = swap ? (eb - ea) : (ea - eb);
      sh     = (32'(diff) > SH_MAX) ? EXP_W'(SH_MAX) : diff;
      mb_in  = {swap ? mant_a : mant_b, 2'b00};
      mb_al  = mb_in >> sh;
      lost_mask = ~({(MAN_W+3){1'b1}} << sh);

      s1_sign_d = swap ? sb : sa;
      s1_sub_d  = sa ^ sb;
      s1_exp_d  = swap ? eb : ea;
      s1_ma_d   = {swap ? mant_b : mant_a, 3'b000};
      s1_mb_d   = {mb_al, |(mb_in & lost_mask)};

      s1_spc_d.nan  = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
      s1_spc_d.inv  = a_inf & b_inf & (sa ^ sb);
      s1_spc_d.inf  = a_inf | b_inf;
      s1_spc_d.sgn  = a_inf ? sa : sb;
      s1_spc_d.zsgn = sa & sb;
   end

   // ---------------- S2: magnitude add / subtract ----------------
   logic             s2_sign_q;
   logic [EXP_W-1:0] s2_exp_q;
   logic [MX:0]      s2_sum_d, s2_sum_q;
   spc_t             s2_spc_q;

   // A >= B after the swap, so the difference never goes negative.
   assign s2_sum_d = s1_sub_q ? ({1'b0, s1_ma_q} - {1'b0, s1_mb_q})
                              : ({1'b0, s1_ma_q} + {1'b0, s1_mb_q});

   // ---------------- S3: normalise / round / pack ----------------
   logic [LZ_W-1:0]         lz;
   logic [MX-1:0]           nrm;
   logic signed [EXP_W+1:0] e;
   logic [MAN_W+1:0]        mr;
   logic [MAN_W-1:0]        frac;
   logic                    rnd, inx;
   logic [W-1:0]            res_d, res_q;
   logic [3:0]              flg_d, flg_q;

   always_comb begin
      lz = lzc(s2_sum_q[MX-1:0]);
      if (s2_sum_q[MX]) begin
         // Carry out: shift right one, the dropped bit joins sticky.
         nrm = {s2_sum_q[MX:2], |s2_sum_q[1:0]};
         e   = $signed({2'b00, s2_exp_q}) + 1;
      end else begin
         nrm = s2_sum_q[MX-1:0] << lz;
         e   = $signed({2'b00, s2_exp_q}) - $signed((EXP_W+2)'(lz));
      end
      rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
      inx = |nrm[2:0];
      mr  = {1'b0, nrm[MX-1:3]} + (MAN_W+2)'(rnd);
      if (mr[MAN_W+1]) begin
         frac = mr[MAN_W:1];
         e    = e + 1;
      end else begin
         frac = mr[MAN_W-1:0];
      end

      res_d = {s2_sign_q, e[EXP_W-1:0], frac};
      flg_d = {3'b000, inx};
      if (s2_spc_q.nan) begin
         res_d = QNAN;
         flg_d = {s2_spc_q.inv, 3'b000};
      end else if (s2_spc_q.inf) begin
         res_d = {s2_spc_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_d = 4'b0000;
      end else if (s2_sum_q == '0) begin
         res_d = {s2_spc_q.zsgn, {(W-1){1'b0}}};
         flg_d = 4'b0000;
      end else if (e >= EMAX) begin
         res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flg_d = 4'b0101;
      end else if (e <= 0) begin
         res_d = {s2_sign_q, {(W-1){1'b0}}};
         flg_d = 4'b0011;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_q     <= '0;
         s1_sign_q <= 1'b0;
         s1_sub_q  <= 1'b0;
         s1_exp_q  <= '0;
         s1_ma_q   <= '0;
         s1_mb_q   <= '0;
         s1_spc_q  <= '0;
         s2_sign_q <= 1'b0;
         s2_exp_q  <= '0;
         s2_sum_q  <= '0;
         s2_spc_q  <= '0;
         res_q     <= '0;
         flg_q     <= '0;
      end else if (en) begin
         vld_q     <= vld_d;
         s1_sign_q <= s1_sign_d;
         s1_sub_q  <= s1_sub_d;
         s1_exp_q  <= s1_exp_d;
         s1_ma_q   <= s1_ma_d;
         s1_mb_q   <= s1_mb_d;
         s1_spc_q  <= s1_spc_d;
         s2_sign_q <= s1_sign_q;
         s2_exp_q  <= s1_exp_q;
         s2_sum_q  <= s2_sum_d;
         s2_spc_q  <= s1_spc_q;
         res_q     <= res_d;
         flg_q     <= flg_d;
      end
   end

   assign o_data  = res_q;
   assign o_flags = flg_q;
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe. Expected results are queued when an operand pair
// is accepted and popped when a result is consumed. Random operations are
// checked against an exact-integer reference for half precision.
module tb_fp_addsub_pipe;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, i_valid, o_ready, i_op, o_valid, i_ready;
   logic [15:0] d1, d2, o_data;
   logic [3:0]  o_flags;

   logic        v2, rdy2_o, op2, ov2, r2;
   logic [31:0] a2, b2, od2;
   logic [3:0]  of2;

   fp_addsub_pipe dut (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
      .data_1(d1), .data_2(d2), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_flags(o_flags));

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
      .i_clk(clk), .i_rst(rst), .i_valid(v2), .o_ready(rdy2_o), .i_op(op2),
      .data_1(a2), .data_2(b2), .o_valid(ov2), .i_ready(r2),
      .o_data(od2), .o_flags(of2));

   int          n_chk = 0;
   int          n_pass = 0;
   logic [19:0] sb_q[$];
   logic [19:0] mon_exp;
   logic [19:0] hold;
   logic        done;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Exact reference: values held as integers in units of 2^-24.
   function automatic logic [19:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                           input logic op);
      logic   sa, sb, an, bn, ai, bi, rs, inx;
      int     ea, eb, p, e, sh;
      longint va, vb, sum, mag, m, rem, half;
      sa = a[15]; sb = b[15] ^ op;
      ea = int'(a[14:10]); eb = int'(b[14:10]);
      an = (ea == 31) && (a[9:0] != 0); ai = (ea == 31) && (a[9:0] == 0);
      bn = (eb == 31) && (b[9:0] != 0); bi = (eb == 31) && (b[9:0] == 0);
      if (an || bn) return {4'b0000, 16'h7E00};
      if (ai && bi && (sa != sb)) return {4'b1000, 16'h7E00};
      if (ai) return {4'b0000, sa, 15'h7C00};
      if (bi) return {4'b0000, sb, 15'h7C00};
      va = 0; vb = 0;
      if (ea != 0) va = 64'({1'b1, a[9:0]}) << (ea - 1);
      if (eb != 0) vb = 64'({1'b1, b[9:0]}) << (eb - 1);
      sum = (sa ? -va : va) + (sb ? -vb : vb);
      if (sum == 0) return {4'b0000, (sa && sb), 15'h0000};
      rs  = (sum < 0);
      mag = rs ? -sum : sum;
      p = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      e = p - 9;
      if (e <= 0) return {4'b0011, rs, 15'h0000};
      sh  = e - 1;
      m   = mag >>> sh;
      rem = mag - (m <<< sh);
      inx = (rem != 0);
      if (sh > 0) begin
         half = longint'(1) <<< (sh - 1);
         if (rem > half || (rem == half && m[0])) m++;
      end
      if (m == 2048) begin m = 1024; e++; end
      if (e >= 31) return {4'b0101, rs, 15'h7C00};
      return {3'b000, inx, rs, 5'(e), 10'(m)};
   endfunction

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [19:0] exp);
      int t = 0;
      @(negedge clk);
      i_valid = 1'b1; d1 = a; d2 = b; i_op = op;
      #1;
      while (!o_ready && t < 50) begin
         @(negedge clk); #1; t++;
      end
      if (t >= 50) check("send_timeout", 32'(o_ready), 1);
      else sb_q.push_back(exp);
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 100) begin
         @(negedge clk); t++;
      end
      check("drain", 32'(sb_q.size()), 0);
   endtask

   // Result consumer: a transfer happens at the next rising edge.
   always @(negedge clk) begin
      #2;
      if (!rst && o_valid && i_ready) begin
         check("sb_has_entry", 32'(sb_q.size() != 0), 1);
         if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            check("result", {12'h0, o_flags, o_data}, {12'h0, mon_exp});
         end
      end
   end

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_op = 1'b0; d1 = '0; d2 = '0; i_ready = 1'b1;
      v2 = 1'b0; op2 = 1'b0; a2 = '0; b2 = '0; r2 = 1'b1; done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_o_valid", 32'(o_valid), 0);
      check("rst_o_data", 32'(o_data), 0);
      check("rst_o_flags", 32'(o_flags), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_o_ready", 32'(o_ready), 1);

      // Basic add and its latency.
      send(16'h3C00, 16'h4000, 1'b0, {4'h0, 16'h4200});
      idle();
      @(negedge clk);
      check("lat_not_yet", 32'(o_valid), 0);
      @(negedge clk);
      check("lat_3", 32'(o_valid), 1);
      drain();

      // Directed corners.
      send(16'h3C00, 16'h3C00, 1'b1, {4'h0, 16'h0000});
      send(16'h8000, 16'h8000, 1'b0, {4'h0, 16'h8000});
      send(16'h3C00, 16'h1000, 1'b0, {4'h1, 16'h3C00});
      send(16'h3C01, 16'h1000, 1'b0, {4'h1, 16'h3C02});
      send(16'h3C00, 16'h0001, 1'b0, {4'h0, 16'h3C00});
      send(16'h7C00, 16'hFC00, 1'b0, {4'h8, 16'h7E00});
      send(16'h7BFF, 16'h7BFF, 1'b0, {4'h5, 16'h7C00});
      send(16'h7E00, 16'h3C00, 1'b0, {4'h0, 16'h7E00});
      send(16'h0400, 16'h0401, 1'b1, {4'h3, 16'h8000});
      send(16'hFC00, 16'h7C00, 1'b1, {4'h0, 16'hFC00});
      send(16'h3C00, 16'h8000, 1'b1, {4'h0, 16'h3C00});
      idle();
      drain();

      // Back-to-back stream with a 4-cycle stall.
      fork
         begin
            send(16'h3C00, 16'h3C00, 1'b0, ref_add(16'h3C00, 16'h3C00, 1'b0));
            send(16'h4500, 16'h3800, 1'b1, ref_add(16'h4500, 16'h3800, 1'b1));
            send(16'hC200, 16'h4100, 1'b0, ref_add(16'hC200, 16'h4100, 1'b0));
            send(16'h5640, 16'h2E66, 1'b0, ref_add(16'h5640, 16'h2E66, 1'b0));
            send(16'h3555, 16'hB555, 1'b1, ref_add(16'h3555, 16'hB555, 1'b1));
            send(16'h6000, 16'h1400, 1'b1, ref_add(16'h6000, 16'h1400, 1'b1));
            idle();
         end
         begin
            repeat (4) @(negedge clk);
            i_ready = 1'b0;
            #1;
            hold = {o_flags, o_data};
            check("stall_valid", 32'(o_valid), 1);
            check("stall_ready", 32'(o_ready), 0);
            for (int k = 1; k < 4; k++) begin
               @(negedge clk); #1;
               check("stall_ready", 32'(o_ready), 0);
               check("stall_hold", {12'h0, o_flags, o_data}, {12'h0, hold});
            end
            @(negedge clk);
            i_ready = 1'b1;
         end
      join
      drain();

      // Reset with two operations in flight.
      send(16'h3C00, 16'h4000, 1'b0, ref_add(16'h3C00, 16'h4000, 1'b0));
      send(16'h4000, 16'h4000, 1'b0, ref_add(16'h4000, 16'h4000, 1'b0));
      @(negedge clk);
      i_valid = 1'b0; rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      check("rst_mid_o_valid", 32'(o_valid), 0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_o_ready", 32'(o_ready), 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("no_stale", 32'(o_valid), 0);
      end

      // Single-precision instance.
      @(negedge clk);
      v2 = 1'b1; a2 = 32'h3F80_0000; b2 = 32'h4000_0000;
      @(negedge clk);
      v2 = 1'b0;
      for (int t = 0; t < 10 && !ov2; t++) @(negedge clk);
      check("sp_valid", 32'(ov2), 1);
      check("sp_data", od2, 32'h4040_0000);
      check("sp_flags", 32'(of2), 0);

      // Random operations with random backpressure.
      fork
         begin
            for (int k = 0; k < 10000; k++) begin
               logic [15:0] ra, rb;
               logic        rop;
               ra  = 16'($urandom);
               rb  = ($urandom_range(3) == 0) ? (ra ^ 16'($urandom_range(255))) : 16'($urandom);
               rop = 1'($urandom_range(1));
               send(ra, rb, rop, ref_add(ra, rb, rop));
            end
            idle();
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               i_ready = ($urandom_range(3) != 0);
            end
            i_ready = 1'b1;
         end
      join
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
